regfile_write_arbiter: RTL and testbench

//   Shares the register file's single write port among NUM_REQ writeback sources
//   (e.g. ALU, load unit, mult/div). Uses valid/ready handshakes and grants at

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_arb_grant.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback request type used by the
// write-port arbiter and its grant logic.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // 'reg' is a keyword, so the index field is called addr.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/wb_arb_grant.sv
// Combinational valid -> one-hot grant. The search starts at ptr_i and wraps;
// a constant zero pointer gives lowest-index-wins fixed priority.
module wb_arb_grant
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  int idx;

  // Scan from the pointer, wrapping once around all requesters.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!grant_any_o && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
        grant_any_o  = 1'b1;
      end else begin
        grant_any_o = grant_any_o;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources with a
// one-cycle registered write stage and a saturating stall counter.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      ctrl_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [IDX_W-1:0]          grant_id,
  output logic [CNT_W-1:0]          stall_count
);

  logic [IDX_W-1:0]   ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic               grant_any_s;
  logic               accept_s;
  logic [ADDR_W-1:0]  sel_reg_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [7:0]         valid_ext_s;
  logic               multi_s;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  reg_q, reg_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  wb_arb_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_grant (
    .valid_i     (req_valid),
    .ptr_i       (ptr_s),
    .grant_o     (grant_s),
    .grant_idx_o (sel_idx_s),
    .grant_any_o (grant_any_s)
  );

  // No handshake completes while reset is held.
  assign req_ready = grant_s & {NUM_REQ{ctrl_reset_n}};
  assign accept_s  = grant_any_s & ctrl_reset_n;

  assign sel_reg_s  = req_reg[int'(sel_idx_s)*ADDR_W +: ADDR_W];
  assign sel_data_s = req_data[int'(sel_idx_s)*DATA_W +: DATA_W];

`ifdef REGFILE_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      if (sel_idx_s == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = sel_idx_s + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = '0;
`endif

  // Contention detect over a zero-extended valid vector.
  always_comb begin
    valid_ext_s                = 8'd0;
    valid_ext_s[NUM_REQ-1:0]   = req_valid;
    multi_s                    = multi_hot(valid_ext_s);
  end

  // Next state of the write stage; r0 writes are accepted but never strobed.
  always_comb begin
    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (accept_s) begin
      we_d   = (sel_reg_s != ADDR_W'(REG_ZERO));
      reg_d  = sel_reg_s;
      data_d = sel_data_s;
      gid_d  = sel_idx_s;
    end else begin
      we_d = 1'b0;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    stall_d = stall_q;
    if (multi_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Output write stage and counter registers.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_q    <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= we_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      stall_q <= stall_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = reg_q;
  assign data_writeReg    = data_q;
  assign grant_id         = gid_q;
  assign stall_count      = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: requester model plus a
// scoreboard queue of expected write-port states, one task per scenario.
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic           clock = 1'b0;
  logic           ctrl_reset_n = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*AW-1:0] req_reg = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           ctrl_writeEnable;
  logic [AW-1:0]  ctrl_writeReg;
  logic [DW-1:0]  data_writeReg;
  logic [1:0]     grant_id;
  logic [CW-1:0]  stall_count;

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .req_valid(req_valid),
    .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .grant_id(grant_id), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
    logic [1:0]  gid;
    logic [3:0]  stall;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_pass  = 0;

  // requester model
  logic [2:0]  pend;
  logic [2:0]  reload;
  logic [4:0]  sreg[3];
  logic [31:0] sdata[3];
  // expected DUT state
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [1:0]  m_gid;
  int          m_stall;
  int          m_ptr;
  // observed DUT outputs
  logic [2:0]  o_ready;
  logic        o_we;
  logic [4:0]  o_reg;
  logic [31:0] o_data;
  logic [1:0]  o_gid;
  logic [3:0]  o_stall;

  function automatic int m_arb(input logic [2:0] v, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend = 3'b000; reload = 3'b000;
    m_reg = 5'd0; m_data = 32'd0; m_gid = 2'd0; m_stall = 0; m_ptr = 0;
    sb_q.delete();
  endtask

  task automatic drive_inputs();
    req_valid = pend;
    for (int i = 0; i < 3; i++) begin
      req_reg[i*AW +: AW]  = sreg[i];
      req_data[i*DW +: DW] = sdata[i];
    end
  endtask

  task automatic apply_reset();
    ctrl_reset_n = 1'b0;
    model_reset();
    drive_inputs();
    @(negedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
  endtask

  // One clock: drive, snapshot ready, push expectation, clock, snapshot outputs.
  task automatic run_cycle();
    int w;
    int cnt;
    exp_t e;
    drive_inputs();
    #1;
    o_ready = req_ready;
    w = m_arb(pend, m_ptr);
    cnt = 0;
    for (int i = 0; i < 3; i++) if (pend[i]) cnt++;
    if (cnt > 1 && m_stall < 15) m_stall++;
    e.ready = 3'b000;
    e.we = 1'b0;
    if (w >= 0) begin
      e.ready[w] = 1'b1;
      e.we   = (sreg[w] != 5'd0);
      m_reg  = sreg[w];
      m_data = sdata[w];
      m_gid  = 2'(w);
`ifdef REGFILE_ARB_RR_EN
      m_ptr = (w + 1) % 3;
`endif
      if (!reload[w]) pend[w] = 1'b0;
    end
    e.rg = m_reg; e.data = m_data; e.gid = m_gid; e.stall = 4'(m_stall);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    o_we = ctrl_writeEnable; o_reg = ctrl_writeReg; o_data = data_writeReg;
    o_gid = grant_id; o_stall = stall_count;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    ctrl_reset_n = 1'b0;
    model_reset();
    pend = 3'b111;
    for (int i = 0; i < 3; i++) begin sreg[i] = 5'(i + 3); sdata[i] = 32'(i + 100); end
    drive_inputs();
    @(posedge clock); #1;
    n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready got=%b want=000", req_ready); else n_pass++;
    n_total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL reset_we got=%b want=0", ctrl_writeEnable); else n_pass++;
    n_total++; if (stall_count !== 4'd0) $display("FAIL reset_stall got=%0d want=0", stall_count); else n_pass++;
    n_total++; if ({ctrl_writeReg, data_writeReg, grant_id} !== 39'd0)
      $display("FAIL reset_regs got=%h/%h/%0d want=0/0/0", ctrl_writeReg, data_writeReg, grant_id); else n_pass++;
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    pend = 3'b001; sreg[0] = 5'd4; sdata[0] = 32'h1234;
    drive_inputs();
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL inflight_ready got=%b want=001", req_ready); else n_pass++;
    #1 ctrl_reset_n = 1'b0;
    @(posedge clock); #1;
    n_total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL inflight_we got=%b want=0", ctrl_writeEnable); else n_pass++;
    @(negedge clock);
    apply_reset();
  endtask

  task automatic test_single();
    exp_t e;
    apply_reset();
    pend = 3'b010; sreg[1] = 5'd7; sdata[1] = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      e = sb_q.pop_front();
      n_total++; if (o_ready !== e.ready) $display("FAIL single_ready c=%0d got=%b want=%b", c, o_ready, e.ready); else n_pass++;
      n_total++; if ({o_we, o_reg, o_data, o_gid} !== {e.we, e.rg, e.data, e.gid})
        $display("FAIL single_out c=%0d got=%b/%0d/%h/%0d want=%b/%0d/%h/%0d", c, o_we, o_reg, o_data, o_gid, e.we, e.rg, e.data, e.gid);
      else n_pass++;
    end
    n_total++; if ({o_reg, o_data, o_gid} !== {5'd7, 32'hDEADBEEF, 2'd1})
      $display("FAIL single_hold got=%0d/%h/%0d want=7/deadbeef/1", o_reg, o_data, o_gid); else n_pass++;
  endtask

  task automatic test_priority();
    exp_t e;
    apply_reset();
    pend = 3'b111;
    for (int i = 0; i < 3; i++) begin sreg[i] = 5'(i + 1); sdata[i] = 32'hA000 + 32'(i); end
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      e = sb_q.pop_front();
      n_total++; if (o_ready !== e.ready) $display("FAIL prio_ready c=%0d got=%b want=%b", c, o_ready, e.ready); else n_pass++;
      n_total++; if ({o_we, o_reg, o_data, o_gid, o_stall} !== {e.we, e.rg, e.data, e.gid, e.stall})
        $display("FAIL prio_out c=%0d got=%b/%0d/%h/%0d/%0d want=%b/%0d/%h/%0d/%0d", c, o_we, o_reg, o_data, o_gid, o_stall,
                 e.we, e.rg, e.data, e.gid, e.stall);
      else n_pass++;
      n_total++; if (o_gid !== 2'(c) || o_we !== 1'b1) $display("FAIL prio_order c=%0d got=%0d/%b want=%0d/1", c, o_gid, o_we, c); else n_pass++;
    end
    n_total++; if (o_stall !== 4'd2) $display("FAIL prio_stall got=%0d want=2", o_stall); else n_pass++;
  endtask

  task automatic test_arbitration_order();
    exp_t e;
    int want[4];
`ifdef REGFILE_ARB_RR_EN
    want = '{0, 1, 2, 0};
`else
    want = '{0, 0, 0, 0};
`endif
    apply_reset();
    pend = 3'b111; reload = 3'b001;
    for (int i = 0; i < 3; i++) begin sreg[i] = 5'(i + 10); sdata[i] = 32'hB000 + 32'(i); end
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      e = sb_q.pop_front();
      n_total++; if (o_ready !== e.ready) $display("FAIL arb_ready c=%0d got=%b want=%b", c, o_ready, e.ready); else n_pass++;
      n_total++; if ({o_gid, o_data} !== {e.gid, e.data})
        $display("FAIL arb_out c=%0d got=%0d/%h want=%0d/%h", c, o_gid, o_data, e.gid, e.data); else n_pass++;
      n_total++; if (o_gid !== 2'(want[c])) $display("FAIL arb_seq c=%0d got=%0d want=%0d", c, o_gid, want[c]); else n_pass++;
    end
  endtask

  task automatic test_r0();
    exp_t e;
    apply_reset();
    pend = 3'b100; sreg[2] = 5'd0; sdata[2] = 32'd5;
    run_cycle();
    e = sb_q.pop_front();
    n_total++; if (o_ready !== 3'b100) $display("FAIL r0_ready got=%b want=100", o_ready); else n_pass++;
    n_total++; if (o_we !== 1'b0 || o_we !== e.we) $display("FAIL r0_we got=%b want=0", o_we); else n_pass++;
  endtask

  task automatic test_same_reg();
    exp_t e;
    apply_reset();
    pend = 3'b011; sreg[0] = 5'd9; sreg[1] = 5'd9; sdata[0] = 32'hAAAA; sdata[1] = 32'hBBBB;
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      e = sb_q.pop_front();
      n_total++; if ({o_we, o_reg, o_data, o_gid} !== {e.we, e.rg, e.data, e.gid})
        $display("FAIL samereg_out c=%0d got=%b/%0d/%h/%0d want=%b/%0d/%h/%0d", c, o_we, o_reg, o_data, o_gid, e.we, e.rg, e.data, e.gid);
      else n_pass++;
    end
    n_total++; if (o_data !== 32'hBBBB) $display("FAIL samereg_last got=%h want=bbbb", o_data); else n_pass++;
  endtask

  task automatic test_saturation();
    exp_t e;
    apply_reset();
    pend = 3'b011; reload = 3'b011;
    sreg[0] = 5'd1; sreg[1] = 5'd2; sdata[0] = 32'h11; sdata[1] = 32'h22;
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      e = sb_q.pop_front();
      n_total++; if ({o_stall, o_gid} !== {e.stall, e.gid})
        $display("FAIL sat_cnt c=%0d got=%0d/%0d want=%0d/%0d", c, o_stall, o_gid, e.stall, e.gid); else n_pass++;
    end
    n_total++; if (o_stall !== 4'd15) $display("FAIL sat_final got=%0d want=15", o_stall); else n_pass++;
    pend = 3'b000; reload = 3'b000;
    drive_inputs();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin sreg[i] = 5'd0; sdata[i] = 32'd0; end
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_arbitration_order();
    test_r0();
    test_same_reg();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
